// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the request sources, the arbiter and the UART transmitter.
// The arbiter takes the master side; requesters and the transmitter see the slave side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            Req;
    logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
    logic [NUM_REQ-1:0]            Grant;
    logic                          TxStart;
    logic [DATA_WIDTH-1:0]         TxData;
    logic                          TxBusy;
    logic                          Active;
    logic                          TimeoutErr;

    modport master (
        input  Req, ReqData, TxBusy,
        output Grant, TxStart, TxData, Active, TimeoutErr
    );

    modport slave (
        output Req, ReqData, TxBusy,
        input  Grant, TxStart, TxData, Active, TimeoutErr
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// It grants one byte, pulses TxStart, and follows TxBusy to completion or timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 15
) (
    input  logic              CLOCK,
    input  logic              Reset,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } ArbStateT;

    ArbStateT              state, stateNext;
    logic [PTR_W-1:0]      lastPtr, lastPtrNext;
    logic [7:0]            timeoutCnt, timeoutCntNext;
    logic [NUM_REQ-1:0]    grantReg, grantNext;
    logic                  txStartReg, txStartNext;
    logic [DATA_WIDTH-1:0] txDataReg, txDataNext;
    logic                  activeReg, activeNext;
    logic                  timeoutErrReg, timeoutErrNext;

    logic                  found;
    logic [PTR_W-1:0]      selIdx;
    logic [PTR_W-1:0]      candIdx;
    logic [DATA_WIDTH-1:0] reqByte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
        assign reqByte[g] = bus.ReqData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        found   = 1'b0;
        selIdx  = '0;
        candIdx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            candIdx = PTR_W'((int'(lastPtr) + i) % NUM_REQ);
            if (!found && bus.Req[candIdx]) begin
                found  = 1'b1;
                selIdx = candIdx;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext      = state;
        lastPtrNext    = lastPtr;
        timeoutCntNext = timeoutCnt;
        grantNext      = '0;
        txStartNext    = 1'b0;
        txDataNext     = txDataReg;
        timeoutErrNext = 1'b0;

        unique case (state)
            IDLE: begin
                if (found && !bus.TxBusy) begin
                    grantNext   = NUM_REQ'(1) << selIdx;
                    txDataNext  = reqByte[selIdx];
                    lastPtrNext = selIdx;
                    stateNext   = START;
                end
            end
            START: begin
                txStartNext    = 1'b1;
                timeoutCntNext = '0;
                stateNext      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.TxBusy) begin
                    stateNext = WAIT_DONE;
                end else if (timeoutCnt == 8'(START_TIMEOUT)) begin
                    // Transmitter never acknowledged: drop the byte, keep the advanced pointer.
                    timeoutErrNext = 1'b1;
                    stateNext      = IDLE;
                end else begin
                    timeoutCntNext = timeoutCnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.TxBusy) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        activeNext = (stateNext != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            lastPtr       <= PTR_W'(NUM_REQ - 1);
            timeoutCnt    <= '0;
            grantReg      <= '0;
            txStartReg    <= 1'b0;
            txDataReg     <= '0;
            activeReg     <= 1'b0;
            timeoutErrReg <= 1'b0;
        end else begin
            state         <= stateNext;
            lastPtr       <= lastPtrNext;
            timeoutCnt    <= timeoutCntNext;
            grantReg      <= grantNext;
            txStartReg    <= txStartNext;
            txDataReg     <= txDataNext;
            activeReg     <= activeNext;
            timeoutErrReg <= timeoutErrNext;
        end
    end

    assign bus.Grant      = grantReg;
    assign bus.TxStart    = txStartReg;
    assign bus.TxData     = txDataReg;
    assign bus.Active     = activeReg;
    assign bus.TimeoutErr = timeoutErrReg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a monitor
// compares them as the DUT presents them; a small transmitter model answers TxStart.
module tb_uart_tx_arbiter;
    logic CLOCK = 1'b0;
    logic Reset;
    always #5 CLOCK = ~CLOCK;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .START_TIMEOUT(15)) dut (
        .CLOCK (CLOCK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
    } ExpT;

    ExpT  expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   grantCount = 0;
    int   lastGrantCyc = -10;
    int   lastStartCyc = -10;
    int   timeoutCount = 0;
    int   lastTimeoutCyc = -10;
    int   activeFallCyc = -10;
    int   busyLowCyc = -10;
    int   forceFallCyc = 0;
    logic activeAtTimeout = 1'b1;
    logic prevActive = 1'b0;

    logic modelBusy = 1'b0;
    logic forceBusy = 1'b0;
    logic respondEn = 1'b1;
    int   busyDelay = 2;
    int   busyLen = 20;

    assign bus.TxBusy = modelBusy | forceBusy;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per Grant and tracks pulse timing.
    initial begin
        ExpT e;
        forever begin
            @(negedge CLOCK);
            if (bus.Grant != 4'b0) begin
                grantCount++;
                lastGrantCyc = cyc;
                if (expQ.size() == 0) begin
                    check("unexpected grant", 32'(bus.Grant), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    check("grant", 32'(bus.Grant), 32'(e.grant));
                    check("txdata", 32'(bus.TxData), 32'(e.data));
                    check("active at grant", 32'(bus.Active), 32'h1);
                end
            end
            if (bus.TxStart) begin
                check("txstart latency", 32'(cyc), 32'(lastGrantCyc + 1));
                lastStartCyc = cyc;
            end
            if (bus.TimeoutErr) begin
                timeoutCount++;
                lastTimeoutCyc  = cyc;
                activeAtTimeout = bus.Active;
            end
            if (prevActive && !bus.Active) activeFallCyc = cyc;
            prevActive = bus.Active;
        end
    end

    // Transmitter model: raises busy busyDelay cycles after TxStart, holds it busyLen cycles.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (bus.TxStart && respondEn) begin
                repeat (busyDelay - 1) @(negedge CLOCK);
                modelBusy = 1'b1;
                repeat (busyLen) @(negedge CLOCK);
                modelBusy  = 1'b0;
                busyLowCyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic waitGrants(input int n, input int budget);
        int t = 0;
        while (grantCount < n && t < budget) begin
            tick();
            t++;
        end
        check("grant count", 32'(grantCount), 32'(n));
    endtask

    task automatic waitIdle(input int budget);
        int t = 0;
        while ((bus.Active || bus.TxBusy || expQ.size() != 0) && t < budget) begin
            tick();
            t++;
        end
        check("reached idle", 32'(t < budget), 32'h1);
    endtask

    task automatic issue(input logic [3:0] req, input logic [3:0] grant, input logic [7:0] data);
        expQ.push_back('{grant: grant, data: data});
        bus.Req = req;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b0;
        bus.Req     = 4'b0;
        bus.ReqData = 32'h0;
        repeat (3) tick();
        check("reset grant", 32'(bus.Grant), 32'h0);
        check("reset txstart", 32'(bus.TxStart), 32'h0);
        check("reset txdata", 32'(bus.TxData), 32'h0);
        check("reset active", 32'(bus.Active), 32'h0);
        check("reset timeouterr", 32'(bus.TimeoutErr), 32'h0);
        Reset = 1'b1;
        tick();

        // Single request from requester 0.
        bus.ReqData = 32'h0000_0041;
        issue(4'b0001, 4'b0001, 8'h41);
        waitGrants(1, 10);
        bus.Req = 4'b0;
        waitIdle(60);
        check("active fall after busy", 32'(activeFallCyc), 32'(busyLowCyc + 1));

        // Fresh pointer, all four requesting: strict rotation.
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        busyLen     = 3;
        bus.ReqData = 32'h4030_2010;
        expQ.push_back('{grant: 4'b0001, data: 8'h10});
        expQ.push_back('{grant: 4'b0010, data: 8'h20});
        expQ.push_back('{grant: 4'b0100, data: 8'h30});
        bus.Req = 4'b1111;
        expQ.push_back('{grant: 4'b1000, data: 8'h40});
        waitGrants(5, 200);
        bus.Req = 4'b0;
        waitIdle(60);

        // Pointer lands on 1, then 0011 wraps around to requester 0.
        bus.ReqData = 32'h4433_2211;
        issue(4'b0010, 4'b0010, 8'h22);
        waitGrants(6, 10);
        bus.Req = 4'b0;
        waitIdle(60);
        issue(4'b0011, 4'b0001, 8'h11);
        waitGrants(7, 10);
        bus.Req = 4'b0;
        waitIdle(60);

        // Transmitter never answers: timeout 16 cycles after TxStart.
        respondEn = 1'b0;
        issue(4'b0100, 4'b0100, 8'h33);
        waitGrants(8, 10);
        bus.Req = 4'b0;
        begin
            int t = 0;
            while (timeoutCount == 0 && t < 40) begin
                tick();
                t++;
            end
        end
        check("timeout count", 32'(timeoutCount), 32'h1);
        check("timeout delay", 32'(lastTimeoutCyc - lastStartCyc), 32'd16);
        check("active at timeout", 32'(activeAtTimeout), 32'h0);
        tick();
        check("timeout pulse width", 32'(bus.TimeoutErr), 32'h0);
        respondEn = 1'b1;
        issue(4'b1000, 4'b1000, 8'h44);
        waitGrants(9, 10);
        bus.Req = 4'b0;
        waitIdle(60);

        // Busy transmitter in IDLE blocks the grant until it clears.
        forceBusy = 1'b1;
        bus.Req   = 4'b0100;
        repeat (6) tick();
        check("no grant while busy", 32'(grantCount), 32'd9);
        expQ.push_back('{grant: 4'b0100, data: 8'h33});
        forceBusy    = 1'b0;
        forceFallCyc = cyc;
        waitGrants(10, 10);
        check("grant after busy falls", 32'(lastGrantCyc), 32'(forceFallCyc + 1));
        bus.Req = 4'b0;
        waitIdle(60);

        // Asynchronous reset during WAIT_DONE, then requester 0 has priority again.
        busyLen = 20;
        issue(4'b0001, 4'b0001, 8'h11);
        waitGrants(11, 10);
        bus.Req = 4'b0;
        repeat (6) tick();
        check("active before reset", 32'(bus.Active), 32'h1);
        #1;
        Reset = 1'b0;
        #1;
        check("async reset active", 32'(bus.Active), 32'h0);
        check("async reset txdata", 32'(bus.TxData), 32'h0);
        check("async reset grant", 32'(bus.Grant), 32'h0);
        tick();
        Reset = 1'b1;
        begin
            int t = 0;
            while (modelBusy && t < 40) begin
                tick();
                t++;
            end
        end
        tick();
        issue(4'b0011, 4'b0001, 8'h11);
        waitGrants(12, 10);
        bus.Req = 4'b0;
        waitIdle(60);

        check("scoreboard drained", 32'(expQ.size()), 32'h0);
        check("total timeouts", 32'(timeoutCount), 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
